// File: rtl/halut_pkg.sv
// rtl/halut_pkg.sv - shared types and constants for the HALUT result path
package halut_pkg;

    localparam int FP32Width         = 32;
    localparam int HalutDecoderUnits = 16;
    localparam int HalutDecAddrWidth = $clog2(HalutDecoderUnits);

    // One buffered decoder result; last marks the final M index of a burst.
    typedef struct packed {
        logic [FP32Width-1:0]         data;
        logic [HalutDecAddrWidth-1:0] m_addr;
        logic                         last;
    } halut_result_t;

endpackage

// File: rtl/halut_result_fifo.sv
// rtl/halut_result_fifo.sv - show-ahead flop-array FIFO of halut_result_t
//
// Purpose: synchronous FIFO, head entry visible on data_o without a read
// strobe. Storage flops carry no reset; data_o is forced to 0 when empty so
// stale contents never leak out.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (pointers/fill only)
//   clear_i        synchronous flush, dominates push and pop
//   push_i/data_i  write request and entry; ignored when full without pop
//   pop_i          advance head; ignored when empty
//   data_o         head entry (0 when empty)
//   full_o/empty_o occupancy flags
//   fill_o         occupancy count, 0..Depth
module halut_result_fifo
    import halut_pkg::*;
#(
    parameter int Depth     = 32,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  halut_result_t        data_i,
    input  logic                 pop_i,
    output halut_result_t        data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [AddrWidth:0]   fill_o
);

    halut_result_t          mem_q [Depth];
    halut_result_t          mem_d [Depth];
    logic [AddrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AddrWidth:0]     fill_q, fill_d;
    logic                   do_push;
    logic                   do_pop;

    assign empty_o = (fill_q == '0);
    assign full_o  = (fill_q == (AddrWidth + 1)'(Depth));
    assign fill_o  = fill_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                // Depth is a power of two, so the pointer wraps naturally.
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fill_d = fill_q + 1'b1;
                2'b01:   fill_d = fill_q - 1'b1;
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/halut_result_collector.sv
// rtl/halut_result_collector.sv - buffers the serialized HALUT result stream
//
// Purpose: accepts one FP32 result per cycle from the decoder array (no
// backpressure), checks M-index ordering, buffers results and re-presents
// them on a ready/valid handshake.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   result_i, m_addr_i   incoming result and its M index, qualified by valid_i
//   clear_i              synchronous flush of FIFO, counters and flags
//   out_data_o, out_m_addr_o, out_last_o, out_valid_o, out_ready_i
//                        show-ahead output handshake
//   fill_o               FIFO occupancy
//   overflow_o           sticky: a result was dropped on a full FIFO
//   seq_err_o            sticky: an M index arrived out of order
//   burst_cnt_o          completed bursts accepted (wrapping)
module halut_result_collector
    import halut_pkg::*;
#(
    parameter int DecoderUnits  = HalutDecoderUnits,
    parameter int FifoDepth     = 32,
    parameter int DecAddrWidth  = $clog2(DecoderUnits),
    parameter int FifoAddrWidth = $clog2(FifoDepth)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [FP32Width-1:0]     result_i,
    input  logic                     valid_i,
    input  logic [DecAddrWidth-1:0]  m_addr_i,
    input  logic                     clear_i,
    output logic [FP32Width-1:0]     out_data_o,
    output logic [DecAddrWidth-1:0]  out_m_addr_o,
    output logic                     out_last_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [FifoAddrWidth:0]   fill_o,
    output logic                     overflow_o,
    output logic                     seq_err_o,
    output logic [15:0]              burst_cnt_o
);

    localparam logic [DecAddrWidth-1:0] LastIdx = DecAddrWidth'(DecoderUnits - 1);

    halut_result_t              in_entry;
    halut_result_t              head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;
    logic                       push;
    logic                       drop;
    logic                       in_last;

    logic [DecAddrWidth-1:0]    exp_q, exp_d;
    logic                       overflow_q, overflow_d;
    logic                       seq_err_q, seq_err_d;
    logic [15:0]                burst_cnt_q, burst_cnt_d;

    assign in_last         = (m_addr_i == LastIdx);
    assign in_entry.data   = result_i;
    assign in_entry.m_addr = m_addr_i;
    assign in_entry.last   = in_last;

    assign pop  = ~fifo_empty & out_ready_i;
    // The input side cannot be stalled: anything not pushed is lost.
    assign push = valid_i & ~clear_i & (~fifo_full | pop);
    assign drop = valid_i & ~clear_i & fifo_full & ~pop;

    halut_result_fifo #(
        .Depth     (FifoDepth),
        .AddrWidth (FifoAddrWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .data_i  (in_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fill_o)
    );

    assign out_valid_o  = ~fifo_empty;
    assign out_data_o   = head.data;
    assign out_m_addr_o = head.m_addr;
    assign out_last_o   = head.last;

    // Sequence checker: a burst always starts at index 0 because exp_q falls
    // back to 0 whenever valid_i drops. A mismatch resyncs to the observed
    // index so a single glitch raises only one error event.
    always_comb begin
        exp_d       = exp_q;
        overflow_d  = overflow_q;
        seq_err_d   = seq_err_q;
        burst_cnt_d = burst_cnt_q;
        if (clear_i) begin
            exp_d       = '0;
            overflow_d  = 1'b0;
            seq_err_d   = 1'b0;
            burst_cnt_d = '0;
        end else begin
            if (valid_i) begin
                if (m_addr_i != exp_q) begin
                    seq_err_d = 1'b1;
                end
                exp_d = in_last ? '0 : m_addr_i + 1'b1;
            end else begin
                exp_d = '0;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
            if (push && in_last) begin
                burst_cnt_d = burst_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_q       <= '0;
            overflow_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            exp_q       <= exp_d;
            overflow_q  <= overflow_d;
            seq_err_q   <= seq_err_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign seq_err_o   = seq_err_q;
    assign burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_halut_result_collector.sv
// tb/tb_halut_result_collector.sv - self-checking bench for halut_result_collector
module tb_halut_result_collector;

    localparam int UNITS = 16;
    localparam int DEPTH = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] result_i = '0;
    logic        valid_i = 1'b0;
    logic [3:0]  m_addr_i = '0;
    logic        clear_i = 1'b0;
    logic [31:0] out_data_o;
    logic [3:0]  out_m_addr_o;
    logic        out_last_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [5:0]  fill_o;
    logic        overflow_o;
    logic        seq_err_o;
    logic [15:0] burst_cnt_o;

    halut_result_collector dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .result_i     (result_i),
        .valid_i      (valid_i),
        .m_addr_i     (m_addr_i),
        .clear_i      (clear_i),
        .out_data_o   (out_data_o),
        .out_m_addr_o (out_m_addr_o),
        .out_last_o   (out_last_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .fill_o       (fill_o),
        .overflow_o   (overflow_o),
        .seq_err_o    (seq_err_o),
        .burst_cnt_o  (burst_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a queue of accepted results plus the expected index.
    typedef struct {
        logic [31:0] d;
        logic [3:0]  m;
    } ent_t;

    ent_t        mq[$];
    int          m_exp;
    logic        m_ovf;
    logic        m_serr;
    logic [15:0] m_bc;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic        v;
        logic [3:0]  m;
        logic        rdy;
        logic        clr;
        logic        e_serr;
        logic        e_ovf;
        int          e_fill;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_exp  = 0;
        m_ovf  = 1'b0;
        m_serr = 1'b0;
        m_bc   = '0;
    endtask

    task automatic compare_model();
        check("out_valid", 32'(out_valid_o), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("out_data", out_data_o, mq[0].d);
            check("out_m_addr", 32'(out_m_addr_o), 32'(mq[0].m));
            check("out_last", 32'(out_last_o), 32'(int'(mq[0].m) == UNITS - 1));
        end else begin
            check("out_data_empty", out_data_o, 32'h0);
            check("out_last_empty", 32'(out_last_o), 32'h0);
        end
        check("fill", 32'(fill_o), mq.size());
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        check("seq_err", 32'(seq_err_o), 32'(m_serr));
        check("burst_cnt", 32'(burst_cnt_o), 32'(m_bc));
    endtask

    // Called at a negedge; drives one cycle, advances the model, and returns
    // at the following negedge after comparing.
    task automatic apply(input logic v, input logic [31:0] d, input logic [3:0] m,
                         input logic rdy, input logic clr);
        bit pop_m;
        bit full_m;
        valid_i     = v;
        result_i    = d;
        m_addr_i    = m;
        out_ready_i = rdy;
        clear_i     = clr;
        @(posedge clk_i);
        if (clr) begin
            model_reset();
        end else begin
            pop_m  = (mq.size() > 0) && rdy;
            full_m = (mq.size() == DEPTH);
            if (v) begin
                if (int'(m) != m_exp) m_serr = 1'b1;
                m_exp = (int'(m) + 1) % UNITS;
            end else begin
                m_exp = 0;
            end
            if (pop_m) void'(mq.pop_front());
            if (v) begin
                if (!full_m || pop_m) begin
                    mq.push_back('{d, m});
                    if (int'(m) == UNITS - 1) m_bc = m_bc + 16'd1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(negedge clk_i);
        compare_model();
    endtask

    function automatic vec_t mk(input logic v, input int m, input logic rdy, input logic clr,
                                input logic serr, input logic ovf, input int fill);
        vec_t r;
        r.v = v; r.m = 4'(m); r.rdy = rdy; r.clr = clr;
        r.e_serr = serr; r.e_ovf = ovf; r.e_fill = fill;
        return r;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(out_valid_o), 32'h0);
        check({tag, "_data"}, out_data_o, 32'h0);
        check({tag, "_m_addr"}, 32'(out_m_addr_o), 32'h0);
        check({tag, "_last"}, 32'(out_last_o), 32'h0);
        check({tag, "_fill"}, 32'(fill_o), 32'h0);
        check({tag, "_overflow"}, 32'(overflow_o), 32'h0);
        check({tag, "_seq_err"}, 32'(seq_err_o), 32'h0);
        check({tag, "_burst_cnt"}, 32'(burst_cnt_o), 32'h0);
    endtask

    initial begin
        // Sequence-error and burst-restart vectors, expected values after each cycle.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 3, 0, 0, 1, 0, 3));
        tbl.push_back(mk(1, 4, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, i, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, i, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0));

        model_reset();
        repeat (3) @(negedge clk_i);
        check_reset_values("reset");
        rst_ni = 1'b1;

        // Full burst, drained one cycle behind.
        for (int i = 0; i < UNITS; i++) begin
            apply(1'b1, 32'h3F80_0000 + 32'(i), 4'(i), 1'b1, 1'b0);
            check("burst_head_data", out_data_o, 32'h3F80_0000 + 32'(i));
            check("burst_head_last", 32'(out_last_o), 32'(i == UNITS - 1));
        end
        check("burst_cnt_one", 32'(burst_cnt_o), 32'd1);
        check("burst_flags", 32'({overflow_o, seq_err_o}), 32'h0);
        apply(1'b0, '0, '0, 1'b1, 1'b0);

        // Table-driven sequence checks.
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].v, 32'hA000_0000 + 32'(i), tbl[i].m, tbl[i].rdy, tbl[i].clr);
            check($sformatf("tbl%0d_seq_err", i), 32'(seq_err_o), 32'(tbl[i].e_serr));
            check($sformatf("tbl%0d_overflow", i), 32'(overflow_o), 32'(tbl[i].e_ovf));
            check($sformatf("tbl%0d_fill", i), 32'(fill_o), 32'(tbl[i].e_fill));
        end

        // Backpressure: three bursts into a 32-deep FIFO.
        apply(1'b0, '0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 48; k++) apply(1'b1, 32'(k), 4'(k % UNITS), 1'b0, 1'b0);
        check("ovf_fill_sat", 32'(fill_o), 32'd32);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_burst_cnt", 32'(burst_cnt_o), 32'd2);
        for (int k = 0; k < 32; k++) begin
            check("drain_data", out_data_o, 32'(k));
            check("drain_m_addr", 32'(out_m_addr_o), 32'(k % UNITS));
            apply(1'b0, '0, '0, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(fill_o), 32'd0);

        // Push at full with simultaneous pop.
        apply(1'b0, '0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 32; k++) apply(1'b1, 32'h5000 + 32'(k), 4'(k % UNITS), 1'b0, 1'b0);
        apply(1'b1, 32'h5020, 4'd0, 1'b1, 1'b0);
        check("fullpop_fill", 32'(fill_o), 32'd32);
        check("fullpop_ovf", 32'(overflow_o), 32'd0);
        check("fullpop_head", out_data_o, 32'h5001);
        for (int k = 0; k < 32; k++) apply(1'b0, '0, '0, 1'b1, 1'b0);

        // Clear with 5 entries held, both flags set, concurrent valid.
        apply(1'b0, '0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 33; k++) apply(1'b1, 32'h7000 + 32'(k), 4'(k % UNITS), 1'b0, 1'b0);
        apply(1'b1, 32'h7777, 4'd9, 1'b0, 1'b0);
        for (int k = 0; k < 27; k++) apply(1'b0, '0, '0, 1'b1, 1'b0);
        check("preclr_fill", 32'(fill_o), 32'd5);
        check("preclr_flags", 32'({overflow_o, seq_err_o}), 32'h3);
        apply(1'b1, 32'h1234, 4'd0, 1'b0, 1'b1);
        check("clr_fill", 32'(fill_o), 32'd0);
        check("clr_flags", 32'({overflow_o, seq_err_o}), 32'h0);
        check("clr_burst_cnt", 32'(burst_cnt_o), 32'd0);
        check("clr_valid", 32'(out_valid_o), 32'd0);

        // Asynchronous reset mid-burst, then valid high across release.
        for (int k = 0; k < 20; k++) apply(1'b1, 32'h9000 + 32'(k), 4'(k % UNITS), 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1 check_reset_values("midrst");
        model_reset();
        valid_i  = 1'b1;
        m_addr_i = 4'd5;
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply(1'b1, 32'hBEEF, 4'd5, 1'b0, 1'b0);
        check("rst_release_seq_err", 32'(seq_err_o), 32'd1);
        check("rst_release_fill", 32'(fill_o), 32'd1);
        apply(1'b0, '0, '0, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            logic       v;
            logic [3:0] m;
            v = ($urandom_range(0, 9) < 7);
            m = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_exp);
            apply(v, $urandom, m, ($urandom_range(0, 9) < 5), ($urandom_range(0, 99) < 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
